univ_shift_reg_ne: RTL and testbench
====================================

# univ_shift_reg_ne

Parametrised negative-edge universal shift register built as the next generation of the lab's single-bit D flip-flop with reset. It holds a WIDTH-bit word and, under a 3-bit mode code, holds, parallel-loads, shifts or rotates on every falling clock edge. It provides true and complemented outputs plus serial outputs at both ends. It is the storage and serialisation element for the upcoming counter and serial-link labs.

## Interface
- WIDTH, 4, register width in bits; legal range is 2 or more.
- C  input  1  clock; all state changes on its falling edge.
- RE  input  1  reset; asynchronous, active-low.
- MODE  input  3  operation select; see Operation.
- D  input  WIDTH  parallel load data.
- SI_L  input  1  serial input entering bit 0 on a shift left.
- SI_R  input  1  serial input entering bit WIDTH-1 on a shift right.
- Q  output  WIDTH  register contents.
- Qnot  output  WIDTH  bitwise complement of Q at all times, including during reset.
- SO_L  output  1  equals Q[WIDTH-1].
- SO_R  output  1  equals Q[0].

## Operation
- Mode codes:
  - 000 HOLD
  - 001 LOAD: Q <= D
  - 010 SHL: Q <= {Q[WIDTH-2:0], SI_L}
  - 011 SHR: Q <= {SI_R, Q[WIDTH-1:1]}
  - 100 ROTL: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}
  - 101 ROTR: Q <= {Q[0], Q[WIDTH-1:1]}
  - 110 CLR: Q <= 0, synchronous
  - 111 reserved; behaves exactly as HOLD.
- Next-state logic is purely combinational from MODE, D, SI_L, SI_R and Q. It feeds one flip-flop per bit.
- RE low forces Q = 0, Qnot = all ones, SO_L = 0 and SO_R = 0 immediately. No clock edge is needed. Reset overrides every mode.
- Reset values: Q = 0, Qnot = {WIDTH{1}}, SO_L = 0, SO_R = 0.
- Reset asserted mid-operation discards the in-progress word. Register contents are not retained.
- Serial outputs are taken from the current Q, not the next state. On a shift, the bit leaving the register is visible on SO_L/SO_R before the falling edge that removes it.

## Timing
- Latency is one falling edge. MODE, D, SI_L and SI_R are sampled at the falling edge of C, and Q updates right after it. Rising edges have no effect.
- Inputs must be stable around the falling edge. They may change freely while C is low or high between falling edges.
- RE deassertion (rising) takes effect asynchronously. The first state change after reset occurs at the first falling edge of C with RE high.
- If RE rises at the same instant as a falling edge of C, that edge is ignored and Q stays 0. Benches must not rely on that edge being captured.
- If RE falls at the same instant as a falling edge of C, reset wins.
- Rotations conserve the population count of Q.
- After WIDTH consecutive SHL edges, Q holds the last WIDTH SI_L samples, with the oldest sample in Q[WIDTH-1]. SHR is the mirror image.

## Structure
- Shared package shift_pkg holds the MODE localparams (MODE_HOLD … MODE_CLR) and the mode width constant of 3.
- One sub-module, dff_ne_ar: a single-bit negative-edge D flip-flop with asynchronous active-low reset and a Qnot output. It is instantiated WIDTH times with a generate loop.
- The top level contains only the next-state mux and the output wiring.

## Test plan
All cases use WIDTH = 4.
- Reset: RE=0 with MODE=001 and D=1111, toggling C → Q=0000 and Qnot=1111 throughout. Then RE=1, MODE=001, D=1010, one falling edge → Q=1010, Qnot=0101, SO_L=1, SO_R=0.
- Shift left: from Q=0000, MODE=010 with SI_L=1,0,1,1 on four edges → Q=1011. Then a fifth edge with SI_L=0 → Q=0110; SO_L was 1 before that edge.
- Rotate: load 1000. Four ROTR edges → Q goes 0100, 0010, 0001, 1000. Then ROTL once → 0001. Popcount stays 1 throughout.
- Hold and reserved: Q=0110 with MODE=000 for 3 edges, then MODE=111 for 3 edges → Q stays 0110. Then CLR for one edge → Q=0000.
- Mid-operation reset: during a SHR sequence from Q=1111, pull RE low between edges → Q=0000 immediately. Release RE together with a falling edge → Q remains 0000. The next edge with SHR and SI_R=1 → Q=1000.
- Edge sensitivity: change MODE to LOAD with D=0101 only while C is high, then restore HOLD before the falling edge → Q unchanged.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared mode encodings for the universal shift register.
package shift_pkg;

    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROTL = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ROTR = 3'b101;
    localparam logic [MODE_W-1:0] MODE_CLR  = 3'b110;
    localparam logic [MODE_W-1:0] MODE_RSVD = 3'b111;

endpackage

// File: rtl/dff_ne_ar.sv
// Single-bit falling-edge D flip-flop with asynchronous active-low reset.
module dff_ne_ar (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic qnot
);

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

    // Complement tracks q continuously, so it reads all ones while in reset.
    assign qnot = ~q;

endmodule

// File: rtl/univ_shift_reg_ne.sv
// WIDTH-bit falling-edge universal shift register: hold, load, shift, rotate, clear.
module univ_shift_reg_ne
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic              C,
    input  logic              RE,
    input  logic [MODE_W-1:0] MODE,
    input  logic [WIDTH-1:0]  D,
    input  logic              SI_L,
    input  logic              SI_R,
    output logic [WIDTH-1:0]  Q,
    output logic [WIDTH-1:0]  Qnot,
    output logic              SO_L,
    output logic              SO_R
);

    logic [WIDTH-1:0] q_next_c;

    // Next-state mux; reserved code falls through to hold.
    always_comb begin
        q_next_c = Q;
        case (MODE)
            MODE_LOAD: q_next_c = D;
            MODE_SHL:  q_next_c = {Q[WIDTH-2:0], SI_L};
            MODE_SHR:  q_next_c = {SI_R, Q[WIDTH-1:1]};
            MODE_ROTL: q_next_c = {Q[WIDTH-2:0], Q[WIDTH-1]};
            MODE_ROTR: q_next_c = {Q[0], Q[WIDTH-1:1]};
            MODE_CLR:  q_next_c = '0;
            default:   q_next_c = Q;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_ne_ar u_dff (
            .clk   (C),
            .rst_n (RE),
            .d     (q_next_c[i]),
            .q     (Q[i]),
            .qnot  (Qnot[i])
        );
    end

    // Serial outputs show the bit about to leave, taken from current state.
    assign SO_L = Q[WIDTH-1];
    assign SO_R = Q[0];

endmodule

// File: tb/tb_univ_shift_reg_ne.sv
// Self-checking bench for univ_shift_reg_ne (WIDTH = 4) with a scoreboard queue.
`timescale 1ns/1ps
module tb_univ_shift_reg_ne;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROTL = 3'b100;
    localparam logic [2:0] M_ROTR = 3'b101;
    localparam logic [2:0] M_CLR  = 3'b110;
    localparam logic [2:0] M_RSVD = 3'b111;

    logic       C;
    logic       RE;
    logic [2:0] MODE;
    logic [3:0] D;
    logic       SI_L;
    logic       SI_R;
    logic [3:0] Q;
    logic [3:0] Qnot;
    logic       SO_L;
    logic       SO_R;

    int checks = 0;
    int passes = 0;
    logic [3:0] sb[$];
    logic [3:0] exp_q;
    logic [3:0] model_q;

    univ_shift_reg_ne #(.WIDTH(4)) dut (
        .C    (C),
        .RE   (RE),
        .MODE (MODE),
        .D    (D),
        .SI_L (SI_L),
        .SI_R (SI_R),
        .Q    (Q),
        .Qnot (Qnot),
        .SO_L (SO_L),
        .SO_R (SO_R)
    );

    initial C = 1'b1;
    always #5 C = ~C;

    initial begin
        #90000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "timeout");
    end

    function automatic logic [3:0] model_next(input logic [2:0] m, input logic [3:0] d,
                                              input logic [3:0] q, input logic sil,
                                              input logic sir);
        case (m)
            M_LOAD:  return d;
            M_SHL:   return {q[2:0], sil};
            M_SHR:   return {sir, q[3:1]};
            M_ROTL:  return {q[2:0], q[3]};
            M_ROTR:  return {q[0], q[3:1]};
            M_CLR:   return 4'b0000;
            default: return q;
        endcase
    endfunction

    // Drive inputs while C is high, then sample just after the falling edge.
    task automatic drive_edge(input logic [2:0] m, input logic [3:0] d,
                              input logic sil, input logic sir);
        @(posedge C);
        #1;
        MODE = m; D = d; SI_L = sil; SI_R = sir;
        @(negedge C);
        #1;
    endtask

    task automatic test_reset();
        RE = 1'b0; MODE = M_LOAD; D = 4'b1111; SI_L = 1'b1; SI_R = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(C);
            #1;
            checks++;
            if (Q !== 4'b0000 || Qnot !== 4'b1111 || SO_L !== 1'b0 || SO_R !== 1'b0)
                $display("FAIL reset_hold[%0d]: Q=%b Qnot=%b SO_L=%b SO_R=%b, required 0000 1111 0 0",
                         i, Q, Qnot, SO_L, SO_R);
            else passes++;
        end
        @(posedge C);
        #1;
        RE = 1'b1;
        sb.push_back(4'b1010);
        drive_edge(M_LOAD, 4'b1010, 1'b0, 1'b0);
        exp_q = sb.pop_front();
        checks++;
        if (Q !== exp_q || Qnot !== 4'b0101 || SO_L !== 1'b1 || SO_R !== 1'b0)
            $display("FAIL reset_first_load: Q=%b Qnot=%b SO_L=%b SO_R=%b, required %b 0101 1 0",
                     Q, Qnot, SO_L, SO_R, exp_q);
        else passes++;
    endtask

    task automatic test_shift_left();
        logic [3:0] sil_seq;
        logic [3:0] exp_seq [4];
        sil_seq = 4'b1011;
        exp_seq = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
        sb.push_back(4'b0000);
        drive_edge(M_CLR, 4'b1111, 1'b1, 1'b1);
        exp_q = sb.pop_front();
        checks++;
        if (Q !== exp_q) $display("FAIL shl_clear: Q=%b, required %b", Q, exp_q);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(exp_seq[i]);
            drive_edge(M_SHL, 4'b1111, sil_seq[3-i], 1'b1);
            exp_q = sb.pop_front();
            checks++;
            if (Q !== exp_q) $display("FAIL shl_step[%0d]: Q=%b, required %b", i, Q, exp_q);
            else passes++;
        end
        @(posedge C);
        #1;
        MODE = M_SHL; SI_L = 1'b0;
        checks++;
        if (SO_L !== 1'b1) $display("FAIL shl_so_before_edge: SO_L=%b, required 1", SO_L);
        else passes++;
        sb.push_back(4'b0110);
        @(negedge C);
        #1;
        exp_q = sb.pop_front();
        checks++;
        if (Q !== exp_q) $display("FAIL shl_fifth: Q=%b, required %b", Q, exp_q);
        else passes++;
    endtask

    task automatic test_rotate();
        logic [3:0] exp_seq [5];
        logic [2:0] mode_seq [5];
        exp_seq  = '{4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0001};
        mode_seq = '{M_ROTR, M_ROTR, M_ROTR, M_ROTR, M_ROTL};
        sb.push_back(4'b1000);
        drive_edge(M_LOAD, 4'b1000, 1'b0, 1'b0);
        exp_q = sb.pop_front();
        checks++;
        if (Q !== exp_q) $display("FAIL rot_load: Q=%b, required %b", Q, exp_q);
        else passes++;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(exp_seq[i]);
            drive_edge(mode_seq[i], 4'b1111, 1'b1, 1'b1);
            exp_q = sb.pop_front();
            checks++;
            if (Q !== exp_q || $countones(Q) != 1)
                $display("FAIL rot_step[%0d]: Q=%b popcount=%0d, required %b popcount=1",
                         i, Q, $countones(Q), exp_q);
            else passes++;
        end
    endtask

    task automatic test_hold_reserved();
        sb.push_back(4'b0110);
        drive_edge(M_LOAD, 4'b0110, 1'b0, 1'b0);
        exp_q = sb.pop_front();
        checks++;
        if (Q !== exp_q) $display("FAIL hold_load: Q=%b, required %b", Q, exp_q);
        else passes++;
        for (int i = 0; i < 6; i++) begin
            sb.push_back(4'b0110);
            drive_edge((i < 3) ? M_HOLD : M_RSVD, 4'b1001, 1'b1, 1'b1);
            exp_q = sb.pop_front();
            checks++;
            if (Q !== exp_q) $display("FAIL hold_rsvd[%0d]: Q=%b, required %b", i, Q, exp_q);
            else passes++;
        end
        sb.push_back(4'b0000);
        drive_edge(M_CLR, 4'b1111, 1'b1, 1'b1);
        exp_q = sb.pop_front();
        checks++;
        if (Q !== exp_q || Qnot !== 4'b1111)
            $display("FAIL hold_clr: Q=%b Qnot=%b, required %b 1111", Q, Qnot, exp_q);
        else passes++;
    endtask

    task automatic test_mid_reset();
        sb.push_back(4'b1111);
        drive_edge(M_LOAD, 4'b1111, 1'b0, 1'b0);
        exp_q = sb.pop_front();
        sb.push_back(4'b0111);
        drive_edge(M_SHR, 4'b0000, 1'b0, 1'b0);
        exp_q = sb.pop_front();
        checks++;
        if (Q !== exp_q) $display("FAIL midrst_shr: Q=%b, required %b", Q, exp_q);
        else passes++;
        #2;
        RE = 1'b0;
        #1;
        checks++;
        if (Q !== 4'b0000 || Qnot !== 4'b1111 || SO_L !== 1'b0 || SO_R !== 1'b0)
            $display("FAIL midrst_async: Q=%b Qnot=%b SO_L=%b SO_R=%b, required 0000 1111 0 0",
                     Q, Qnot, SO_L, SO_R);
        else passes++;
        // Release coincides with a falling edge; SI_R=0 makes the outcome edge-independent.
        @(posedge C);
        #1;
        MODE = M_SHR; SI_R = 1'b0;
        @(negedge C);
        RE = 1'b1;
        #1;
        checks++;
        if (Q !== 4'b0000) $display("FAIL midrst_release: Q=%b, required 0000", Q);
        else passes++;
        sb.push_back(4'b1000);
        drive_edge(M_SHR, 4'b0000, 1'b0, 1'b1);
        exp_q = sb.pop_front();
        checks++;
        if (Q !== exp_q || SO_L !== 1'b1)
            $display("FAIL midrst_first_shr: Q=%b SO_L=%b, required %b 1", Q, SO_L, exp_q);
        else passes++;
    endtask

    task automatic test_edge_sensitivity();
        sb.push_back(4'b1000);
        drive_edge(M_HOLD, 4'b0000, 1'b0, 1'b0);
        exp_q = sb.pop_front();
        // LOAD present across a rising edge only.
        MODE = M_LOAD; D = 4'b0101;
        @(posedge C);
        #1;
        checks++;
        if (Q !== 4'b1000) $display("FAIL edge_rising: Q=%b, required 1000", Q);
        else passes++;
        MODE = M_HOLD;
        @(posedge C);
        #1;
        MODE = M_LOAD; D = 4'b0101;
        #2;
        MODE = M_HOLD;
        @(negedge C);
        #1;
        checks++;
        if (Q !== 4'b1000) $display("FAIL edge_glitch_load: Q=%b, required 1000", Q);
        else passes++;
    endtask

    task automatic test_random();
        logic [2:0] m;
        logic [3:0] d;
        logic sil;
        logic sir;
        model_q = 4'b0011;
        sb.push_back(model_q);
        drive_edge(M_LOAD, model_q, 1'b0, 1'b0);
        exp_q = sb.pop_front();
        for (int i = 0; i < 60; i++) begin
            m   = 3'($urandom_range(0, 7));
            d   = 4'($urandom);
            sil = 1'($urandom);
            sir = 1'($urandom);
            model_q = model_next(m, d, model_q, sil, sir);
            sb.push_back(model_q);
            drive_edge(m, d, sil, sir);
            exp_q = sb.pop_front();
            checks++;
            if (Q !== exp_q || Qnot !== ~exp_q || SO_L !== exp_q[3] || SO_R !== exp_q[0])
                $display("FAIL random[%0d] mode=%b: Q=%b Qnot=%b SO_L=%b SO_R=%b, required Q=%b",
                         i, m, Q, Qnot, SO_L, SO_R, exp_q);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_shift_left();
        test_rotate();
        test_hold_reserved();
        test_mid_reset();
        test_edge_sensitivity();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
